bfs_path_engine: RTL and testbench

//  Hardware breadth-first flood of the tile maze from one source cell (ghost position), storing a parent

---
 rtl/bfs_path_engine_pkg.sv | 25 ++
 rtl/bfs_path_engine_queue.sv | 55 +++++
 rtl/bfs_path_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_bfs_path_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bfs_path_engine_pkg.sv
// Shared types for the maze flood / path-query engine: direction codes, FSM states and the
// first-step direction helper.
package bfs_path_engine_pkg;

    typedef enum logic [2:0] {
        DirUp    = 3'd0,
        DirLeft  = 3'd1,
        DirDown  = 3'd2,
        DirRight = 3'd3,
        DirNone  = 3'd4
    } dir_e;

    typedef enum logic [3:0] {
        StIdle, StSeed, StPop, StExp0, StExp1, StExp2, StExp3, StWalkRd, StWalkCmp, StResult
    } state_e;

    // Direction of the step from the current cell to its adjacent successor on the chain.
    function automatic dir_e step_dir(input logic same_x, input logic x_inc, input logic y_inc);
        if (same_x) begin
            return y_inc ? DirDown : DirUp;
        end
        return x_inc ? DirRight : DirLeft;
    endfunction

endpackage

// File: rtl/bfs_path_engine_queue.sv
// Circular FIFO of packed {y,x} positions for the flood frontier; pointers carry one extra wrap bit.
module bfs_path_engine_queue #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem_q [Depth];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bfs_path_engine.sv
// Breadth-first flood of the tile maze from a source cell recording a parent per reached cell, then
// parent-chain walks from a target back to the current cell to report the first-step direction.
module bfs_path_engine
    import bfs_path_engine_pkg::*;
#(
    parameter int unsigned COORD_W  = 5,
    parameter int unsigned BOUND    = 28,
    parameter int unsigned QUEUE_AW = 7,
    parameter int unsigned MAX_WALK = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 bfs_start_i,
    input  logic [COORD_W-1:0]   src_x_i,
    input  logic [COORD_W-1:0]   src_y_i,
    output logic                 busy_o,
    output logic                 map_valid_o,
    output logic                 overflow_o,
    output logic [COORD_W-1:0]   wall_x_o,
    output logic [COORD_W-1:0]   wall_y_o,
    input  logic                 wall_i,
    input  logic                 query_valid_i,
    output logic                 query_ready_o,
    input  logic [COORD_W-1:0]   tgt_x_i,
    input  logic [COORD_W-1:0]   tgt_y_i,
    input  logic [COORD_W-1:0]   cur_x_i,
    input  logic [COORD_W-1:0]   cur_y_i,
    output logic                 dir_valid_o,
    output logic [2:0]           dir_o,
    output logic [2*COORD_W-1:0] path_len_o
);
    localparam int unsigned PosW  = 2 * COORD_W;
    localparam int unsigned Cells = 2 ** PosW;
    localparam int unsigned HopW  = $clog2(MAX_WALK + 1);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PosW-1:0]    pos_t;

    function automatic logic legal(input coord_t c);
        return (c != '0) && (32'(c) < BOUND);
    endfunction

    state_e            state_q, state_d;
    logic [Cells-1:0]  visited_q, visited_d;
    pos_t              parent_q [Cells];
    pos_t              par_rdata_q;
    pos_t              cell_q, cell_d, src_q, src_d, tgt_q, tgt_d, cur_q, cur_d, node_q, node_d;
    logic [HopW-1:0]   hop_q, hop_d;
    dir_e              dir_q, dir_d;
    pos_t              len_q, len_d;
    logic              map_valid_q, map_valid_d, overflow_q, overflow_d;

    logic              par_we, q_push, q_pop, q_clr, q_full, q_empty, accept;
    pos_t              par_waddr, par_wdata, q_wdata, q_rdata, nb_pos, tgt_in, cur_in;
    coord_t            nb_x, nb_y, cell_x, cell_y, node_x, node_y, cur_x, cur_y;

    assign {cell_y, cell_x} = cell_q;
    assign {node_y, node_x} = node_q;
    assign {cur_y, cur_x}   = cur_q;
    assign tgt_in = {tgt_y_i, tgt_x_i};
    assign cur_in = {cur_y_i, cur_x_i};

    // Neighbour under test, in expansion order up, left, down, right; wraps mod 2**COORD_W.
    always_comb begin
        nb_x = cell_x;
        nb_y = cell_y;
        case (state_q)
            StExp0:  nb_y = cell_y - 1'b1;
            StExp1:  nb_x = cell_x - 1'b1;
            StExp2:  nb_y = cell_y + 1'b1;
            StExp3:  nb_x = cell_x + 1'b1;
            default: ;
        endcase
    end

    assign nb_pos   = {nb_y, nb_x};
    assign wall_x_o = nb_x;
    assign wall_y_o = nb_y;
    assign accept   = legal(nb_x) && legal(nb_y) && !wall_i && !visited_q[nb_pos];

    always_comb begin
        state_d     = state_q;
        visited_d   = visited_q;
        cell_d      = cell_q;
        src_d       = src_q;
        tgt_d       = tgt_q;
        cur_d       = cur_q;
        node_d      = node_q;
        hop_d       = hop_q;
        dir_d       = dir_q;
        len_d       = len_q;
        map_valid_d = map_valid_q;
        overflow_d  = overflow_q;
        par_we      = 1'b0;
        par_waddr   = nb_pos;
        par_wdata   = cell_q;
        q_push      = 1'b0;
        q_pop       = 1'b0;
        q_clr       = 1'b0;
        q_wdata     = nb_pos;
        if (bfs_start_i) begin
            state_d     = StSeed;
            visited_d   = '0;
            q_clr       = 1'b1;
            overflow_d  = 1'b0;
            map_valid_d = 1'b0;
            src_d       = {src_y_i, src_x_i};
        end else begin
            case (state_q)
                StIdle: begin
                    if (query_valid_i) begin
                        tgt_d  = tgt_in;
                        cur_d  = cur_in;
                        node_d = tgt_in;
                        hop_d  = '0;
                        if (!map_valid_q || !visited_q[tgt_in] || (tgt_in == cur_in)) begin
                            dir_d   = DirNone;
                            len_d   = '0;
                            state_d = StResult;
                        end else begin
                            state_d = StWalkRd;
                        end
                    end
                end
                StSeed: begin
                    // An out-of-bounds source is marked but never expanded.
                    visited_d[src_q] = 1'b1;
                    par_we           = 1'b1;
                    par_waddr        = src_q;
                    par_wdata        = src_q;
                    q_wdata          = src_q;
                    q_push           = legal(src_q[COORD_W-1:0]) && legal(src_q[PosW-1:COORD_W]);
                    state_d          = StPop;
                end
                StPop: begin
                    if (q_empty) begin
                        map_valid_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        cell_d  = q_rdata;
                        q_pop   = 1'b1;
                        state_d = StExp0;
                    end
                end
                StExp0, StExp1, StExp2, StExp3: begin
                    if (accept) begin
                        visited_d[nb_pos] = 1'b1;
                        par_we            = 1'b1;
                        if (q_full) overflow_d = 1'b1;
                        else        q_push     = 1'b1;
                    end
                    case (state_q)
                        StExp0:  state_d = StExp1;
                        StExp1:  state_d = StExp2;
                        StExp2:  state_d = StExp3;
                        default: state_d = StPop;
                    endcase
                end
                StWalkRd: state_d = StWalkCmp;
                StWalkCmp: begin
                    if (par_rdata_q == cur_q) begin
                        dir_d   = step_dir(node_x == cur_x, node_x == cur_x + 1'b1,
                                           node_y == cur_y + 1'b1);
                        len_d   = PosW'(32'(hop_q) + 1);
                        state_d = StResult;
                    end else if ((par_rdata_q == node_q) || (32'(hop_q) == MAX_WALK)) begin
                        dir_d   = DirNone;
                        len_d   = '0;
                        state_d = StResult;
                    end else begin
                        node_d  = par_rdata_q;
                        hop_d   = hop_q + 1'b1;
                        state_d = StWalkRd;
                    end
                end
                StResult: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            visited_q   <= '0;
            cell_q      <= '0;
            src_q       <= '0;
            tgt_q       <= '0;
            cur_q       <= '0;
            node_q      <= '0;
            hop_q       <= '0;
            dir_q       <= DirNone;
            len_q       <= '0;
            map_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            visited_q   <= visited_d;
            cell_q      <= cell_d;
            src_q       <= src_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
            node_q      <= node_d;
            hop_q       <= hop_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            map_valid_q <= map_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Parent RAM: one write per reached cell, synchronous read of the walk node.
    always_ff @(posedge clk_i) begin
        if (par_we) parent_q[par_waddr] <= par_wdata;
        par_rdata_q <= parent_q[node_q];
    end

    bfs_path_engine_queue #(
        .AW(QUEUE_AW),
        .DW(PosW)
    ) u_queue (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (q_clr),
        .push_i (q_push),
        .pop_i  (q_pop),
        .wdata_i(q_wdata),
        .rdata_o(q_rdata),
        .full_o (q_full),
        .empty_o(q_empty)
    );

    assign busy_o        = (state_q != StIdle);
    assign map_valid_o   = map_valid_q;
    assign overflow_o    = overflow_q;
    assign query_ready_o = rst_ni && (state_q == StIdle) && !bfs_start_i;
    assign dir_valid_o   = (state_q == StResult);
    assign dir_o         = dir_q;
    assign path_len_o    = len_q;

endmodule

// File: tb/tb_bfs_path_engine.sv
// Directed bench: a default engine plus a 4-entry-queue engine share all inputs; each sees its own
// wall lookups through a maze function selected per scenario.
module tb_bfs_path_engine;

    logic       clk, rst_n, bfs_start, query_valid;
    logic [4:0] src_x, src_y, tgt_x, tgt_y, cur_x, cur_y;

    logic       busy0, mv0, ov0, qr0, dv0, wall0;
    logic [2:0] dir0;
    logic [9:0] len0;
    logic [4:0] wx0, wy0;
    logic       busy1, mv1, ov1, qr1, dv1, wall1;
    logic [2:0] dir1;
    logic [9:0] len1;
    logic [4:0] wx1, wy1;

    int mode;  // 0 open field, 1 corridor, 2 pocket
    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic wall_at(input logic [4:0] x, input logic [4:0] y);
        logic border;
        border = (x == 0) || (y == 0) || (x >= 27) || (y >= 27);
        if (mode == 1) return border || (x == 10 && y != 5);
        if (mode == 2) begin
            return !((x == 5 && y >= 3 && y <= 6) || (y == 5 && (x == 4 || x == 6)) ||
                     (y == 4 && x >= 2 && x <= 4));
        end
        return border;
    endfunction

    assign wall0 = wall_at(wx0, wy0);
    assign wall1 = wall_at(wx1, wy1);

    bfs_path_engine u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bfs_start_i(bfs_start), .src_x_i(src_x), .src_y_i(src_y),
        .busy_o(busy0), .map_valid_o(mv0), .overflow_o(ov0), .wall_x_o(wx0), .wall_y_o(wy0),
        .wall_i(wall0), .query_valid_i(query_valid), .query_ready_o(qr0), .tgt_x_i(tgt_x),
        .tgt_y_i(tgt_y), .cur_x_i(cur_x), .cur_y_i(cur_y), .dir_valid_o(dv0), .dir_o(dir0),
        .path_len_o(len0)
    );

    bfs_path_engine #(.QUEUE_AW(2)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .bfs_start_i(bfs_start), .src_x_i(src_x), .src_y_i(src_y),
        .busy_o(busy1), .map_valid_o(mv1), .overflow_o(ov1), .wall_x_o(wx1), .wall_y_o(wy1),
        .wall_i(wall1), .query_valid_i(query_valid), .query_ready_o(qr1), .tgt_x_i(tgt_x),
        .tgt_y_i(tgt_y), .cur_x_i(cur_x), .cur_y_i(cur_y), .dir_valid_o(dv1), .dir_o(dir1),
        .path_len_o(len1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles until both engines are idle, or -1 on timeout.
    task automatic run_flood(input logic [4:0] sx, input logic [4:0] sy, output int cyc);
        src_x = sx; src_y = sy; bfs_start = 1'b1;
        step();
        bfs_start = 1'b0;
        cyc = -1;
        for (int c = 0; c < 20000; c++) begin
            if (!busy0 && !busy1) begin cyc = c; break; end
            step();
        end
    endtask

    // lat = cycle index (1 = first cycle after the accepting edge) of dir_valid, -1 on timeout.
    task automatic run_query(input int sel, input logic [4:0] tx, input logic [4:0] ty,
                             input logic [4:0] cx, input logic [4:0] cy, output int lat,
                             output logic [2:0] dir, output logic [9:0] len);
        tgt_x = tx; tgt_y = ty; cur_x = cx; cur_y = cy; query_valid = 1'b1;
        lat = -1; dir = 3'd7; len = '1;
        for (int n = 0; n < 20000; n++) begin
            if ((sel == 1) ? qr1 : qr0) break;
            step();
        end
        step();
        query_valid = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if ((sel == 1) ? dv1 : dv0) begin
                lat = c; dir = (sel == 1) ? dir1 : dir0; len = (sel == 1) ? len1 : len0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bfs_start = 1'b0; query_valid = 1'b0; mode = 0;
        src_x = '0; src_y = '0; tgt_x = '0; tgt_y = '0; cur_x = '0; cur_y = '0;
        step(); step();
        total_cnt++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else pass_cnt++;
        total_cnt++; if (mv0 !== 1'b0) $display("FAIL reset_map_valid: got %b expected 0", mv0); else pass_cnt++;
        total_cnt++; if (ov0 !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ov0); else pass_cnt++;
        total_cnt++; if (dv0 !== 1'b0) $display("FAIL reset_dir_valid: got %b expected 0", dv0); else pass_cnt++;
        total_cnt++; if (dir0 !== 3'd4) $display("FAIL reset_dir: got %0d expected 4", dir0); else pass_cnt++;
        total_cnt++; if (len0 !== 10'd0) $display("FAIL reset_len: got %0d expected 0", len0); else pass_cnt++;
        total_cnt++; if (qr0 !== 1'b0) $display("FAIL reset_ready: got %b expected 0", qr0); else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++; if (qr0 !== 1'b1) $display("FAIL idle_ready: got %b expected 1", qr0); else pass_cnt++;
    endtask

    task automatic test_no_map();
        int lat; logic [2:0] d; logic [9:0] l;
        run_query(0, 5'd1, 5'd1, 5'd2, 5'd2, lat, d, l);
        total_cnt++; if (lat !== 1) $display("FAIL nomap_latency: got %0d expected 1", lat); else pass_cnt++;
        total_cnt++; if (d !== 3'd4) $display("FAIL nomap_dir: got %0d expected 4", d); else pass_cnt++;
    endtask

    task automatic test_illegal_src();
        int cyc, lat; logic [2:0] d; logic [9:0] l;
        mode = 0;
        run_flood(5'd27, 5'd27, cyc);
        total_cnt++; if (cyc < 0) $display("FAIL corner_flood_done: got %0d expected >=0", cyc); else pass_cnt++;
        total_cnt++; if (mv0 !== 1'b1) $display("FAIL corner_map_valid: got %b expected 1", mv0); else pass_cnt++;
        run_query(0, 5'd26, 5'd26, 5'd27, 5'd27, lat, d, l);
        total_cnt++; if (lat !== 1 || d !== 3'd4) $display("FAIL corner_unreached: got lat %0d dir %0d expected lat 1 dir 4", lat, d); else pass_cnt++;
        run_query(0, 5'd27, 5'd27, 5'd1, 5'd1, lat, d, l);
        total_cnt++; if (d !== 3'd4 || l !== 10'd0) $display("FAIL corner_self_parent: got dir %0d len %0d expected dir 4 len 0", d, l); else pass_cnt++;
        run_flood(5'd0, 5'd5, cyc);
        run_query(0, 5'd1, 5'd5, 5'd0, 5'd5, lat, d, l);
        total_cnt++; if (lat !== 1 || d !== 3'd4) $display("FAIL illegal_src_not_expanded: got lat %0d dir %0d expected lat 1 dir 4", lat, d); else pass_cnt++;
    endtask

    task automatic test_open_field();
        int cyc, lat; logic [2:0] d; logic [9:0] l;
        logic [4:0] tx [5] = '{5'd14, 5'd10, 5'd14, 5'd18, 5'd16};
        logic [4:0] ty [5] = '{5'd10, 5'd14, 5'd18, 5'd14, 5'd12};
        logic [2:0] ed [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        mode = 0;
        run_flood(5'd14, 5'd14, cyc);
        total_cnt++; if (mv0 !== 1'b1) $display("FAIL open_map_valid: got %b expected 1", mv0); else pass_cnt++;
        total_cnt++; if (ov0 !== 1'b0) $display("FAIL open_overflow: got %b expected 0", ov0); else pass_cnt++;
        total_cnt++; if (ov1 !== 1'b1) $display("FAIL small_overflow: got %b expected 1", ov1); else pass_cnt++;
        total_cnt++; if (mv1 !== 1'b1) $display("FAIL small_map_valid: got %b expected 1", mv1); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            run_query(0, tx[i], ty[i], 5'd14, 5'd14, lat, d, l);
            total_cnt++;
            if (lat !== 9 || d !== ed[i] || l !== 10'd4)
                $display("FAIL open_query_%0d: got lat %0d dir %0d len %0d expected lat 9 dir %0d len 4", i, lat, d, l, ed[i]);
            else pass_cnt++;
        end
        run_query(0, 5'd14, 5'd14, 5'd14, 5'd14, lat, d, l);
        total_cnt++; if (lat !== 1 || d !== 3'd4 || l !== 10'd0) $display("FAIL open_same_cell: got lat %0d dir %0d len %0d expected 1 4 0", lat, d, l); else pass_cnt++;
        run_query(0, 5'd14, 5'd10, 5'd3, 5'd3, lat, d, l);
        total_cnt++; if (lat !== 11 || d !== 3'd4 || l !== 10'd0) $display("FAIL off_chain: got lat %0d dir %0d len %0d expected 11 4 0", lat, d, l); else pass_cnt++;
    endtask

    task automatic test_corridor();
        int cyc, lat; logic [2:0] d; logic [9:0] l;
        mode = 1;
        run_flood(5'd12, 5'd12, cyc);
        run_query(0, 5'd8, 5'd12, 5'd12, 5'd12, lat, d, l);
        total_cnt++; if (lat !== 37 || d !== 3'd0 || l !== 10'd18) $display("FAIL corridor: got lat %0d dir %0d len %0d expected 37 0 18", lat, d, l); else pass_cnt++;
    endtask

    task automatic test_pocket_overflow();
        int cyc, lat; logic [2:0] d; logic [9:0] l;
        mode = 2;
        run_flood(5'd5, 5'd5, cyc);
        total_cnt++; if (ov1 !== 1'b1 || mv1 !== 1'b1) $display("FAIL pocket_flags: got ov %b mv %b expected 1 1", ov1, mv1); else pass_cnt++;
        total_cnt++; if (ov0 !== 1'b0) $display("FAIL pocket_big_overflow: got %b expected 0", ov0); else pass_cnt++;
        run_query(1, 5'd3, 5'd4, 5'd5, 5'd5, lat, d, l);
        total_cnt++; if (lat !== 1 || d !== 3'd4) $display("FAIL pocket_unreached: got lat %0d dir %0d expected 1 4", lat, d); else pass_cnt++;
        run_query(1, 5'd4, 5'd4, 5'd5, 5'd5, lat, d, l);
        total_cnt++; if (lat !== 5 || d !== 3'd0 || l !== 10'd2) $display("FAIL pocket_dropped_cell: got lat %0d dir %0d len %0d expected 5 0 2", lat, d, l); else pass_cnt++;
    endtask

    task automatic test_abort_walk();
        int cyc, lat, bad_dv, bad_rdy, n; logic [2:0] d; logic [9:0] l;
        mode = 1;
        run_flood(5'd12, 5'd12, cyc);
        tgt_x = 5'd8; tgt_y = 5'd12; cur_x = 5'd12; cur_y = 5'd12; query_valid = 1'b1;
        step();
        query_valid = 1'b0;
        bad_dv = 0; bad_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            if (dv0) bad_dv++;
            step();
        end
        bfs_start = 1'b1;
        step();
        bfs_start = 1'b0;
        total_cnt++; if (busy0 !== 1'b1 || mv0 !== 1'b0) $display("FAIL abort_restart: got busy %b mv %b expected 1 0", busy0, mv0); else pass_cnt++;
        n = 0;
        query_valid = 1'b1;
        while (busy0 && n < 20000) begin
            if (dv0) bad_dv++;
            if (qr0) bad_rdy++;
            step();
            n++;
        end
        query_valid = 1'b0;
        step();
        total_cnt++; if (bad_dv !== 0) $display("FAIL abort_no_dir_valid: got %0d strobes expected 0", bad_dv); else pass_cnt++;
        total_cnt++; if (bad_rdy !== 0) $display("FAIL ready_stalled: got %0d ready cycles expected 0", bad_rdy); else pass_cnt++;
        total_cnt++; if (mv0 !== 1'b1) $display("FAIL abort_reflood_done: got %b expected 1", mv0); else pass_cnt++;
        // Wait out the query accepted as the flood finished.
        for (int c = 0; c < 100 && !qr0; c++) step();
        run_query(0, 5'd8, 5'd12, 5'd12, 5'd12, lat, d, l);
        total_cnt++; if (d !== 3'd0 || l !== 10'd18) $display("FAIL abort_requery: got dir %0d len %0d expected 0 18", d, l); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_map();
        test_illegal_src();
        test_open_field();
        test_corridor();
        test_pocket_overflow();
        test_abort_walk();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
